// File: rtl/polyphase_tx_filter.sv
// ---------------------------------------------------------------------------
// polyphase_tx_filter
//   Multi-channel polyphase BPSK pulse-shaping FIR. Each channel keeps the
//   last N_BAUDS symbol bits; every enabled cycle one of OVER_SAMP phases is
//   computed as a signed sum of +/- coefficients (bit 0 -> +c, bit 1 -> -c).
//   The coefficient bank is runtime-writable and shared by all channels.
//   Two register stages: stage 1 holds the raw accumulators, stage 2 holds
//   the saturated output samples.
//
// Ports
//   clk, i_rst          clock, synchronous active-high reset
//   i_enable            sample-rate strobe gating all progress
//   i_valid / o_ready   symbol handshake: a symbol is consumed in a cycle
//                       where o_ready=1 (last phase of an enabled period);
//                       i_valid outside such a cycle is ignored, and a
//                       missing i_valid there shifts in 0 and sets the
//                       sticky o_underflow flag
//   i_prbs              one symbol bit per channel
//   i_coeff_we/addr/data  coefficient write, addr = phase + OVER_SAMP*baud
//   o_data              N_CH samples, ch0 in LSBs
//   o_valid, o_phase    output qualifier and phase index of o_data
//   o_underflow         sticky underflow flag
// ---------------------------------------------------------------------------
module polyphase_tx_filter #(
    parameter int N_CH      = 2,
    parameter int NB_COEFF  = 10,
    parameter int NBF_COEFF = 8,
    parameter int OVER_SAMP = 8,
    parameter int N_BAUDS   = 7,
    parameter int NB_COUNT  = 3,
    parameter int NB_ADDR   = 6,
    parameter int NB_OUTPUT = 13
) (
    input  logic                      clk,
    input  logic                      i_rst,
    input  logic                      i_enable,
    input  logic                      i_valid,
    input  logic [N_CH-1:0]           i_prbs,
    output logic                      o_ready,
    input  logic                      i_coeff_we,
    input  logic [NB_ADDR-1:0]        i_coeff_addr,
    input  logic [NB_COEFF-1:0]       i_coeff_data,
    output logic [N_CH*NB_OUTPUT-1:0] o_data,
    output logic                      o_valid,
    output logic [NB_COUNT-1:0]       o_phase,
    output logic                      o_underflow
);
    localparam int NB_ACC  = NB_COEFF + 1 + $clog2(N_BAUDS);
    localparam int NB_WIDE = (NB_ACC > NB_OUTPUT) ? NB_ACC : NB_OUTPUT;
    localparam logic signed [NB_WIDE-1:0] SAT_MAX = NB_WIDE'((1 << (NB_OUTPUT - 1)) - 1);
    localparam logic signed [NB_WIDE-1:0] SAT_MIN = -SAT_MAX - 1;

    logic [NB_COUNT-1:0]        cnt_q, cnt_d;
    logic [N_BAUDS-1:0]         sr_q [N_CH];
    logic [N_BAUDS-1:0]         sr_d [N_CH];
    logic signed [NB_COEFF-1:0] coef_q [N_BAUDS][OVER_SAMP];
    logic signed [NB_COEFF-1:0] coef_d [N_BAUDS][OVER_SAMP];
    logic signed [NB_ACC-1:0]   acc_q [N_CH];
    logic signed [NB_ACC-1:0]   acc_d [N_CH];
    logic [NB_COUNT-1:0]        ph1_q, ph1_d;
    logic                       v1_q, v1_d;
    logic signed [NB_OUTPUT-1:0] data_q [N_CH];
    logic signed [NB_OUTPUT-1:0] data_d [N_CH];
    logic                       valid_q, valid_d;
    logic [NB_COUNT-1:0]        phase_q, phase_d;
    logic                       underflow_q, underflow_d;

    logic                       slot;
    logic signed [NB_COEFF:0]   term;
    logic signed [NB_WIDE-1:0]  wide;

    // Symbol slot is the last phase of an enabled sample period.
    assign slot    = i_enable && (cnt_q == NB_COUNT'(OVER_SAMP - 1));
    assign o_ready = slot;

    // Phase counter, symbol shift registers, underflow flag.
    always_comb begin
        cnt_d       = cnt_q;
        underflow_d = underflow_q;
        if (i_enable) begin
            cnt_d = cnt_q + 1'b1;  // OVER_SAMP is a power of 2, so this wraps
        end
        if (slot && !i_valid) begin
            underflow_d = 1'b1;
        end
        for (int ch = 0; ch < N_CH; ch++) begin
            sr_d[ch] = sr_q[ch];
            if (slot) begin
                sr_d[ch] = {sr_q[ch][N_BAUDS-2:0], i_valid ? i_prbs[ch] : 1'b0};
            end
        end
    end

    // Coefficient bank; out-of-range addresses match no entry and are dropped.
    always_comb begin
        for (int k = 0; k < N_BAUDS; k++) begin
            for (int p = 0; p < OVER_SAMP; p++) begin
                coef_d[k][p] = coef_q[k][p];
                if (i_coeff_we && (i_coeff_addr == NB_ADDR'(p + OVER_SAMP * k))) begin
                    coef_d[k][p] = i_coeff_data;
                end
            end
        end
    end

    // Stage 1: reads the registered bank, so a same-cycle write is not seen.
    // Negation happens one bit wider than the coefficient so -(-2^(N-1)) is exact.
    always_comb begin
        term  = '0;
        v1_d  = i_enable;
        ph1_d = i_enable ? cnt_q : ph1_q;
        for (int ch = 0; ch < N_CH; ch++) begin
            acc_d[ch] = acc_q[ch];
            if (i_enable) begin
                acc_d[ch] = '0;
                for (int k = 0; k < N_BAUDS; k++) begin
                    term = $signed({coef_q[k][cnt_q][NB_COEFF-1], coef_q[k][cnt_q]});
                    if (sr_q[ch][k]) begin
                        term = -term;
                    end
                    acc_d[ch] = acc_d[ch] + $signed({{(NB_ACC-NB_COEFF-1){term[NB_COEFF]}}, term});
                end
            end
        end
    end

    // Stage 2: saturate into the output width, hold when nothing new arrives.
    always_comb begin
        wide    = '0;
        valid_d = v1_q;
        phase_d = v1_q ? ph1_q : phase_q;
        for (int ch = 0; ch < N_CH; ch++) begin
            data_d[ch] = data_q[ch];
            if (v1_q) begin
                wide = NB_WIDE'(acc_q[ch]);
                if (wide > SAT_MAX) begin
                    data_d[ch] = SAT_MAX[NB_OUTPUT-1:0];
                end else if (wide < SAT_MIN) begin
                    data_d[ch] = SAT_MIN[NB_OUTPUT-1:0];
                end else begin
                    data_d[ch] = wide[NB_OUTPUT-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            cnt_q       <= '0;
            ph1_q       <= '0;
            v1_q        <= 1'b0;
            valid_q     <= 1'b0;
            phase_q     <= '0;
            underflow_q <= 1'b0;
            for (int ch = 0; ch < N_CH; ch++) begin
                sr_q[ch]   <= '0;
                acc_q[ch]  <= '0;
                data_q[ch] <= '0;
            end
            for (int k = 0; k < N_BAUDS; k++) begin
                for (int p = 0; p < OVER_SAMP; p++) begin
                    coef_q[k][p] <= '0;
                end
            end
        end else begin
            cnt_q       <= cnt_d;
            ph1_q       <= ph1_d;
            v1_q        <= v1_d;
            valid_q     <= valid_d;
            phase_q     <= phase_d;
            underflow_q <= underflow_d;
            for (int ch = 0; ch < N_CH; ch++) begin
                sr_q[ch]   <= sr_d[ch];
                acc_q[ch]  <= acc_d[ch];
                data_q[ch] <= data_d[ch];
            end
            for (int k = 0; k < N_BAUDS; k++) begin
                for (int p = 0; p < OVER_SAMP; p++) begin
                    coef_q[k][p] <= coef_d[k][p];
                end
            end
        end
    end

    always_comb begin
        o_data = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            o_data[ch*NB_OUTPUT +: NB_OUTPUT] = data_q[ch];
        end
    end

    assign o_valid     = valid_q;
    assign o_phase     = phase_q;
    assign o_underflow = underflow_q;

endmodule

// File: tb/tb_polyphase_tx_filter.sv
// Directed bench for polyphase_tx_filter. Two instances share all inputs:
// dut (13-bit output) and dut_s (11-bit output, exercises clamping).
// A behavioural model tracks the expected outputs; hand-derived constants
// pin the key values.
module tb_polyphase_tx_filter;
  logic        clk;
  logic        i_rst;
  logic        i_enable;
  logic        i_valid;
  logic [1:0]  i_prbs;
  logic        i_coeff_we;
  logic [5:0]  i_coeff_addr;
  logic [9:0]  i_coeff_data;
  logic        o_ready;
  logic [25:0] o_data;
  logic        o_valid;
  logic [2:0]  o_phase;
  logic        o_underflow;
  logic        s_ready;
  logic [21:0] s_data;
  logic        s_valid;
  logic [2:0]  s_phase;
  logic        s_underflow;

  wire signed [12:0] d0  = o_data[12:0];
  wire signed [12:0] d1  = o_data[25:13];
  wire signed [10:0] sd0 = s_data[10:0];

  polyphase_tx_filter dut (
    .clk(clk), .i_rst(i_rst), .i_enable(i_enable), .i_valid(i_valid), .i_prbs(i_prbs),
    .o_ready(o_ready), .i_coeff_we(i_coeff_we), .i_coeff_addr(i_coeff_addr),
    .i_coeff_data(i_coeff_data), .o_data(o_data), .o_valid(o_valid), .o_phase(o_phase),
    .o_underflow(o_underflow)
  );

  polyphase_tx_filter #(.NB_OUTPUT(11)) dut_s (
    .clk(clk), .i_rst(i_rst), .i_enable(i_enable), .i_valid(i_valid), .i_prbs(i_prbs),
    .o_ready(s_ready), .i_coeff_we(i_coeff_we), .i_coeff_addr(i_coeff_addr),
    .i_coeff_data(i_coeff_data), .o_data(s_data), .o_valid(s_valid), .o_phase(s_phase),
    .o_underflow(s_underflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- model state ----------------
  int         m_cnt;
  logic [6:0] m_sr [2];
  int         m_coef [56];
  int         m_acc [2];
  int         m_ph1;
  bit         m_v1;
  bit         m_ovalid;
  int         m_odata [2];
  int         m_odata_s [2];
  int         m_phase;
  bit         m_uf;
  bit         m_ready;
  logic       seen_ready;

  function automatic int sat(input int v, input int nb);
    int mx;
    mx = (1 << (nb - 1)) - 1;
    if (v > mx) return mx;
    if (v < -mx - 1) return -mx - 1;
    return v;
  endfunction

  // ---------------- driver ----------------
  // Drives one cycle, samples o_ready before the edge, advances the model at
  // the edge and returns 1 time unit after it.
  task automatic cycle(input bit rst, input bit en, input bit vld, input logic [1:0] prbs,
                       input bit we, input int addr, input int data);
    int s;
    i_rst = rst; i_enable = en; i_valid = vld; i_prbs = prbs;
    i_coeff_we = we; i_coeff_addr = addr[5:0]; i_coeff_data = data[9:0];
    m_ready = en && (m_cnt == 7);
    #1 seen_ready = o_ready;
    @(posedge clk);
    if (rst) begin
      m_cnt = 0; m_ph1 = 0; m_v1 = 0; m_ovalid = 0; m_phase = 0; m_uf = 0;
      for (int c = 0; c < 2; c++) begin
        m_sr[c] = '0; m_acc[c] = 0; m_odata[c] = 0; m_odata_s[c] = 0;
      end
      for (int a = 0; a < 56; a++) m_coef[a] = 0;
    end else begin
      m_ovalid = m_v1;
      if (m_v1) begin
        m_phase = m_ph1;
        for (int c = 0; c < 2; c++) begin
          m_odata[c]   = sat(m_acc[c], 13);
          m_odata_s[c] = sat(m_acc[c], 11);
        end
      end
      m_v1 = en;
      if (en) begin
        m_ph1 = m_cnt;
        for (int c = 0; c < 2; c++) begin
          s = 0;
          for (int k = 0; k < 7; k++)
            s += m_sr[c][k] ? -m_coef[m_cnt + 8 * k] : m_coef[m_cnt + 8 * k];
          m_acc[c] = s;
        end
      end
      if (m_ready) begin
        for (int c = 0; c < 2; c++) m_sr[c] = {m_sr[c][5:0], vld ? prbs[c] : 1'b0};
        if (!vld) m_uf = 1;
      end
      if (en) m_cnt = (m_cnt + 1) % 8;
      if (we && addr < 56) m_coef[addr] = data;
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1, int'($urandom_range(0, 63)), int'($urandom_range(0, 1023)));
      n_checks++; if (o_valid !== 1'b0) $display("FAIL reset_valid got %0d exp 0", o_valid); else n_pass++;
      n_checks++; if (o_data !== 26'd0) $display("FAIL reset_data got %h exp 0", o_data); else n_pass++;
      n_checks++; if (o_underflow !== 1'b0) $display("FAIL reset_uf got %0d exp 0", o_underflow); else n_pass++;
      n_checks++; if (o_phase !== 3'd0) $display("FAIL reset_phase got %0d exp 0", o_phase); else n_pass++;
    end
    for (int i = 0; i < 24; i++) begin
      cycle(0, 1, 1, 2'($urandom_range(0, 3)), 0, 0, 0);
      n_checks++; if (o_valid !== (i >= 1)) $display("FAIL zero_valid got %0d exp %0d", o_valid, i >= 1); else n_pass++;
      n_checks++; if (o_data !== 26'd0) $display("FAIL zero_coef_data got %h exp 0", o_data); else n_pass++;
    end
  endtask

  task automatic test_impulse();
    cycle(1, 0, 1, 2'b00, 0, 0, 0);
    for (int a = 0; a < 56; a++) cycle(0, 0, 0, 2'b00, 1, a, a - 28);
    for (int i = 0; i < 80; i++) begin
      cycle(0, 1, 1, {1'($urandom_range(0, 1)), (i < 8) ? 1'b1 : 1'b0}, 0, 0, 0);
      n_checks++; if (seen_ready !== (i % 8 == 7)) $display("FAIL imp_ready i=%0d got %0d exp %0d", i, seen_ready, i % 8 == 7); else n_pass++;
      if (i >= 1) begin
        n_checks++; if (o_valid !== 1'b1) $display("FAIL imp_valid i=%0d got %0d exp 1", i, o_valid); else n_pass++;
        n_checks++; if (o_phase !== 3'((i - 1) % 8)) $display("FAIL imp_phase i=%0d got %0d exp %0d", i, o_phase, (i - 1) % 8); else n_pass++;
        n_checks++; if (int'(d0) !== m_odata[0]) $display("FAIL imp_ch0 i=%0d got %0d exp %0d", i, d0, m_odata[0]); else n_pass++;
        n_checks++; if (int'(d1) !== m_odata[1]) $display("FAIL imp_ch1 i=%0d got %0d exp %0d", i, d1, m_odata[1]); else n_pass++;
      end
      if (i == 1) begin
        n_checks++; if (d0 !== -13'sd28) $display("FAIL imp_first got %0d exp -28", d0); else n_pass++;
      end
      if (i == 8) begin
        n_checks++; if (d0 !== 13'sd21) $display("FAIL imp_ph7_pre got %0d exp 21", d0); else n_pass++;
      end
      if (i == 9) begin
        n_checks++; if (d0 !== 13'sd28) $display("FAIL imp_ph0_post got %0d exp 28", d0); else n_pass++;
      end
    end
  endtask

  task automatic test_gating();
    cycle(0, 0, 1, 2'b00, 0, 0, 0);
    cycle(0, 0, 1, 2'b00, 0, 0, 0);
    for (int i = 0; i < 30; i++) begin
      cycle(0, (i % 3 == 0), 1, 2'($urandom_range(0, 3)), 0, 0, 0);
      n_checks++; if (o_valid !== (i % 3 == 1)) $display("FAIL gate_valid i=%0d got %0d exp %0d", i, o_valid, i % 3 == 1); else n_pass++;
      n_checks++; if (seen_ready !== m_ready) $display("FAIL gate_ready i=%0d got %0d exp %0d", i, seen_ready, m_ready); else n_pass++;
      n_checks++; if (int'(d0) !== m_odata[0] || int'(d1) !== m_odata[1])
        $display("FAIL gate_data i=%0d got %0d,%0d exp %0d,%0d", i, d0, d1, m_odata[0], m_odata[1]); else n_pass++;
      n_checks++; if (int'(o_phase) !== m_phase) $display("FAIL gate_phase i=%0d got %0d exp %0d", i, o_phase, m_phase); else n_pass++;
    end
  endtask

  task automatic test_underflow();
    bit dropped;
    bit drop_now;
    dropped = 0;
    n_checks++; if (o_underflow !== 1'b0) $display("FAIL uf_initial got %0d exp 0", o_underflow); else n_pass++;
    for (int i = 0; i < 40; i++) begin
      drop_now = (m_cnt == 7) && !dropped && (i > 8);
      cycle(0, 1, !drop_now, drop_now ? 2'b11 : 2'($urandom_range(0, 3)), 0, 0, 0);
      if (drop_now) dropped = 1;
      n_checks++; if (o_underflow !== dropped) $display("FAIL uf_flag i=%0d got %0d exp %0d", i, o_underflow, dropped); else n_pass++;
      n_checks++; if (int'(d0) !== m_odata[0] || int'(d1) !== m_odata[1])
        $display("FAIL uf_data i=%0d got %0d,%0d exp %0d,%0d", i, d0, d1, m_odata[0], m_odata[1]); else n_pass++;
    end
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, 2'b00, 0, 0, 0);
    n_checks++; if (o_underflow !== 1'b1) $display("FAIL uf_sticky got %0d exp 1", o_underflow); else n_pass++;
    cycle(1, 0, 1, 2'b00, 0, 0, 0);
    n_checks++; if (o_underflow !== 1'b0) $display("FAIL uf_clear got %0d exp 0", o_underflow); else n_pass++;
  endtask

  task automatic test_extremes();
    cycle(1, 0, 1, 2'b00, 0, 0, 0);
    for (int a = 0; a < 56; a++) cycle(0, 0, 1, 2'b00, 1, a, -512);
    for (int i = 0; i < 66; i++) cycle(0, 1, 1, 2'b11, 0, 0, 0);
    n_checks++; if (d0 !== 13'sd3584 || d1 !== 13'sd3584) $display("FAIL ext_neg_min got %0d,%0d exp 3584", d0, d1); else n_pass++;
    n_checks++; if (sd0 !== 11'sd1023) $display("FAIL ext_sat_neg_min got %0d exp 1023", sd0); else n_pass++;
    for (int a = 0; a < 56; a++) cycle(0, 0, 1, 2'b00, 1, a, 511);
    for (int i = 0; i < 66; i++) cycle(0, 1, 1, 2'b00, 0, 0, 0);
    n_checks++; if (d0 !== 13'sd3577) $display("FAIL ext_pos got %0d exp 3577", d0); else n_pass++;
    n_checks++; if (sd0 !== 11'sd1023) $display("FAIL ext_sat_pos got %0d exp 1023", sd0); else n_pass++;
    for (int i = 0; i < 66; i++) cycle(0, 1, 1, 2'b11, 0, 0, 0);
    n_checks++; if (d0 !== -13'sd3577) $display("FAIL ext_neg got %0d exp -3577", d0); else n_pass++;
    n_checks++; if (sd0 !== -11'sd1024) $display("FAIL ext_sat_neg got %0d exp -1024", sd0); else n_pass++;
    n_checks++; if (int'(sd0) !== m_odata_s[0]) $display("FAIL ext_sat_model got %0d exp %0d", sd0, m_odata_s[0]); else n_pass++;
  endtask

  task automatic test_write_hazard();
    cycle(1, 0, 1, 2'b00, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      if (i == 3)      cycle(0, 1, 1, 2'b00, 1, 3, 100);
      else if (i == 4) cycle(0, 1, 1, 2'b00, 1, 60, 77);
      else             cycle(0, 1, 1, 2'b00, 0, 0, 0);
      if (i == 4) begin
        n_checks++; if (d0 !== 13'sd0) $display("FAIL wr_old_value got %0d exp 0", d0); else n_pass++;
      end
      if (i == 12) begin
        n_checks++; if (d0 !== 13'sd100 || d1 !== 13'sd100) $display("FAIL wr_new_value got %0d,%0d exp 100", d0, d1); else n_pass++;
      end
      if (i == 13) begin
        n_checks++; if (d0 !== 13'sd0) $display("FAIL wr_addr60_ignored got %0d exp 0", d0); else n_pass++;
      end
      n_checks++; if (int'(d0) !== m_odata[0]) $display("FAIL wr_model i=%0d got %0d exp %0d", i, d0, m_odata[0]); else n_pass++;
    end
    cycle(1, 1, 1, 2'b00, 1, 3, 55);
    n_checks++; if (o_valid !== 1'b0) $display("FAIL wr_rst_drop got %0d exp 0", o_valid); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 1, 2'b00, 0, 0, 0);
      n_checks++; if (o_data !== 26'd0) $display("FAIL wr_rst_bank i=%0d got %h exp 0", i, o_data); else n_pass++;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    i_rst = 1; i_enable = 0; i_valid = 0; i_prbs = 0;
    i_coeff_we = 0; i_coeff_addr = 0; i_coeff_data = 0;
    m_cnt = 0; m_uf = 0; m_v1 = 0; m_ovalid = 0;
    @(posedge clk); #1;
    test_reset();
    test_impulse();
    test_gating();
    test_underflow();
    test_extremes();
    test_write_hazard();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
